sdram_rom_loader: RTL and testbench

//  Turns the HPS ioctl ROM-download byte stream into 16-bit SDRAM word writes.

---
 rtl/sdram_loader_pkg.sv | 24 ++
 rtl/loader_fifo.sv | 64 ++++++
 rtl/sdram_rom_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_rom_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_loader_pkg.sv
// Shared types and constants for the HPS ROM-download to SDRAM loader.
package sdram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN,
    DONE
  } loader_state_t;

  localparam logic [1:0] DS_FULL = 2'b11;
  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;

  // One buffered SDRAM word write; region 1 selects port2.
  typedef struct packed {
    logic        region;
    logic [22:0] a;
    logic [15:0] d;
    logic [1:0]  ds;
  } fifo_entry_t;

endpackage

// File: rtl/loader_fifo.sv
// Word FIFO accepting up to two pushes and one pop per cycle.
// push0 is written ahead of push1 when both are asserted.
module loader_fifo
  import sdram_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push0,
  input  fifo_entry_t              din0,
  input  logic                     push1,
  input  fifo_entry_t              din1,
  input  logic                     pop,
  output fifo_entry_t              head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fifo_entry_t       mem_q [DEPTH];
  fifo_entry_t       mem_d [DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  // Next pointers, occupancy and storage contents for this cycle's pushes/pop.
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    if (push0) begin
      mem_d[wp_d] = din0;
      wp_d        = wp_d + AW'(1);
    end
    if (push1) begin
      mem_d[wp_d] = din1;
      wp_d        = wp_d + AW'(1);
    end
    rp_d  = pop ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push0) + CW'(push1) - CW'(pop);
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rp_q];
  assign count = cnt_q;

endmodule

// File: rtl/sdram_rom_loader.sv
// Packs the HPS ioctl byte stream into 16-bit words, buffers them and
// issues toggle-handshake SDRAM writes on port1 (low region) or port2.
module sdram_rom_loader
  import sdram_loader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter logic [24:0] P2_BASE       = 25'h080000,
  parameter logic [23:0] P1_SDRAM_BASE = 24'h000000,
  parameter logic [23:0] P2_SDRAM_BASE = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic        port1_we,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic        port2_we,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Region is decided from the word's even byte address.
  function automatic fifo_entry_t mk_entry(input logic [22:0] w, input logic [15:0] d,
                                           input logic [1:0] ds);
    fifo_entry_t e;
    e.region = ({1'b0, w, 1'b0} >= P2_BASE);
    e.a      = w;
    e.d      = d;
    e.ds     = ds;
    return e;
  endfunction

  loader_state_t state_q, state_d;
  logic          pend_vld_q, pend_vld_d;
  logic [22:0]   pend_w_q, pend_w_d;
  logic [7:0]    pend_b_q, pend_b_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          port1_req_q, port1_req_d, port1_we_q, port1_we_d;
  logic [22:0]   port1_a_q, port1_a_d;
  logic [1:0]    port1_ds_q, port1_ds_d;
  logic [15:0]   port1_d_q, port1_d_d;
  logic          port2_req_q, port2_req_d, port2_we_q, port2_we_d;
  logic [22:0]   port2_a_q, port2_a_d;
  logic [1:0]    port2_ds_q, port2_ds_d;
  logic [15:0]   port2_d_q, port2_d_d;

  logic          push0, push1, pop;
  fifo_entry_t   din0, din1, head, pend_ent, hi_ent;
  logic [CW-1:0] fifo_cnt;
  logic          take, fifo_full, p1_idle, p2_idle;
  logic [22:0]   w;

  assign w          = ioctl_addr[23:1];
  assign take       = ioctl_wr & ioctl_download & ~ioctl_wait & ~ioctl_addr[24];
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign ioctl_wait = (fifo_cnt > CW'(FIFO_DEPTH - 2));
  assign p1_idle    = (port1_ack == port1_req_q);
  assign p2_idle    = (port2_ack == port2_req_q);
  assign pend_ent   = mk_entry(pend_w_q, {8'h00, pend_b_q}, DS_LO);
  assign hi_ent     = mk_entry(w, {ioctl_dout, 8'h00}, DS_HI);

  loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push0  (push0),
    .din0   (din0),
    .push1  (push1),
    .din1   (din1),
    .pop    (pop),
    .head   (head),
    .count  (fifo_cnt)
  );

  // Byte packing: merge even/odd pairs, push orphan halves with partial strobes.
  always_comb begin
    push0      = 1'b0;
    push1      = 1'b0;
    din0       = pend_ent;
    din1       = hi_ent;
    pend_vld_d = pend_vld_q;
    pend_w_d   = pend_w_q;
    pend_b_d   = pend_b_q;
    if (take) begin
      if (!ioctl_addr[0]) begin
        push0      = pend_vld_q && (pend_w_q != w);
        pend_vld_d = 1'b1;
        pend_w_d   = w;
        pend_b_d   = ioctl_dout;
      end else if (pend_vld_q && (pend_w_q == w)) begin
        push0      = 1'b1;
        din0       = mk_entry(w, {ioctl_dout, pend_b_q}, DS_FULL);
        pend_vld_d = 1'b0;
      end else begin
        push0      = 1'b1;
        push1      = pend_vld_q;
        din0       = pend_vld_q ? pend_ent : hi_ent;
        pend_vld_d = 1'b0;
      end
    end else if (state_q == FLUSH && pend_vld_q && !fifo_full) begin
      push0      = 1'b1;
      pend_vld_d = 1'b0;
    end
  end

  // Download sequencing and the registered busy/done flags.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (take) state_d = LOAD;
      LOAD:    if (!ioctl_download) state_d = FLUSH;
      FLUSH:   if (take) state_d = LOAD;
               else if (!pend_vld_q || !fifo_full) state_d = DRAIN;
      DRAIN:   if (take) state_d = LOAD;
               else if (fifo_cnt == '0 && p1_idle && p2_idle) state_d = DONE;
      DONE:    state_d = take ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // In-order dispatch of the FIFO head to its port when that port is idle.
  always_comb begin
    pop         = 1'b0;
    port1_req_d = port1_req_q;
    port1_we_d  = port1_we_q;
    port1_a_d   = port1_a_q;
    port1_ds_d  = port1_ds_q;
    port1_d_d   = port1_d_q;
    port2_req_d = port2_req_q;
    port2_we_d  = port2_we_q;
    port2_a_d   = port2_a_q;
    port2_ds_d  = port2_ds_q;
    port2_d_d   = port2_d_q;
    if (fifo_cnt != '0) begin
      if (!head.region && p1_idle) begin
        pop         = 1'b1;
        port1_req_d = ~port1_req_q;
        port1_we_d  = 1'b1;
        port1_a_d   = head.a + P1_SDRAM_BASE[23:1];
        port1_ds_d  = head.ds;
        port1_d_d   = head.d;
      end else if (head.region && p2_idle) begin
        pop         = 1'b1;
        port2_req_d = ~port2_req_q;
        port2_we_d  = 1'b1;
        port2_a_d   = head.a - P2_BASE[23:1] - 23'(P2_BASE[0]) + P2_SDRAM_BASE[23:1];
        port2_ds_d  = head.ds;
        port2_d_d   = head.d;
      end
    end
  end

  // State, pending byte and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pend_vld_q  <= 1'b0;
      pend_w_q    <= '0;
      pend_b_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      port1_req_q <= 1'b0;
      port1_we_q  <= 1'b0;
      port1_a_q   <= '0;
      port1_ds_q  <= '0;
      port1_d_q   <= '0;
      port2_req_q <= 1'b0;
      port2_we_q  <= 1'b0;
      port2_a_q   <= '0;
      port2_ds_q  <= '0;
      port2_d_q   <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_w_q    <= pend_w_d;
      pend_b_q    <= pend_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      port1_req_q <= port1_req_d;
      port1_we_q  <= port1_we_d;
      port1_a_q   <= port1_a_d;
      port1_ds_q  <= port1_ds_d;
      port1_d_q   <= port1_d_d;
      port2_req_q <= port2_req_d;
      port2_we_q  <= port2_we_d;
      port2_a_q   <= port2_a_d;
      port2_ds_q  <= port2_ds_d;
      port2_d_q   <= port2_d_d;
    end
  end

  assign port1_req = port1_req_q;
  assign port1_we  = port1_we_q;
  assign port1_a   = port1_a_q;
  assign port1_ds  = port1_ds_q;
  assign port1_d   = port1_d_q;
  assign port2_req = port2_req_q;
  assign port2_we  = port2_we_q;
  assign port2_a   = port2_a_q;
  assign port2_ds  = port2_ds_q;
  assign port2_d   = port2_d_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sdram_rom_loader.sv
// Bench for sdram_rom_loader: directed steps plus a randomized download,
// checked against a byte-image model of what the SDRAM should end up holding.
module tb_sdram_rom_loader;

  localparam logic [24:0] P2B = 25'h080000;

  logic        clk = 1'b0;
  logic        reset_n, ioctl_download, ioctl_wr, ioctl_wait;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        port1_req, port1_we, port2_req, port2_we, busy, done;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic [15:0] port1_d, port2_d;

  int          total = 0, bad = 0;
  logic [7:0]  exp_img [int];
  logic [7:0]  got_img [int];
  logic [40:0] q1 [$];
  logic [40:0] q2 [$];
  bit          hold1 = 1'b0, hold2 = 1'b0, done_idle = 1'b0;
  int          dly1 = 0, dly2 = 0, done_cnt = 0;

  always #5 clk = ~clk;

  sdram_rom_loader dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_we(port1_we), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_we(port2_we), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_d(port2_d),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void store(input int base, input logic [15:0] d, input logic [1:0] ds);
    if (ds[0]) got_img[base]     = d[7:0];
    if (ds[1]) got_img[base + 1] = d[15:8];
  endfunction

  // SDRAM controller model, port1: random ack latency, holdable
  always @(negedge clk) begin
    if (!reset_n) begin
      port1_ack <= 1'b0;
      dly1      <= 0;
    end else if (port1_req !== port1_ack && !hold1) begin
      if (dly1 != 0) dly1 <= dly1 - 1;
      else begin
        store(2 * int'(port1_a), port1_d, port1_ds);
        q1.push_back({port1_a, port1_d, port1_ds});
        port1_ack <= port1_req;
        dly1      <= $urandom_range(0, 3);
      end
    end
  end

  // SDRAM controller model, port2
  always @(negedge clk) begin
    if (!reset_n) begin
      port2_ack <= 1'b0;
      dly2      <= 0;
    end else if (port2_req !== port2_ack && !hold2) begin
      if (dly2 != 0) dly2 <= dly2 - 1;
      else begin
        store(int'(P2B) + 2 * int'(port2_a), port2_d, port2_ds);
        q2.push_back({port2_a, port2_d, port2_ds});
        port2_ack <= port2_req;
        dly2      <= $urandom_range(0, 3);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      done_idle = (port1_req === port1_ack) && (port2_req === port2_ack);
    end
  end

  task automatic wr_byte(input logic [24:0] addr, input logic [7:0] b);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_timeout", 1, 0);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = b;
    @(negedge clk);
    ioctl_wr = 1'b0;
    if (!addr[24]) exp_img[int'(addr)] = b;
  endtask

  // Idle means both ports settled for several cycles (a non-empty FIFO would dispatch).
  task automatic wait_idle(input string tag);
    int n = 0, quiet = 0;
    while (quiet < 4 && n < 500) begin
      @(negedge clk);
      n++;
      if (port1_req === port1_ack && port2_req === port2_ack) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) chk(tag, 0, 1);
  endtask

  task automatic wait_done(input int d0, input int limit, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt, d0 + 1);
  endtask

  initial begin
    logic [7:0] b [12];
    int n, d0, base, len;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    repeat (3) @(negedge clk);
    chk("rst_p1", {port1_req, port1_we, port1_a, port1_ds, port1_d}, 0);
    chk("rst_p2", {port2_req, port2_we, port2_a, port2_ds, port2_d}, 0);
    chk("rst_wait", ioctl_wait, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // full word to port1
    ioctl_download = 1'b1;
    wr_byte(25'h0, 8'h34);
    wr_byte(25'h1, 8'h12);
    n = 0;
    while (port1_req !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    chk("t2_req", port1_req, 1);
    chk("t2_a", port1_a, 0);
    chk("t2_d", port1_d, 16'h1234);
    chk("t2_ds", port1_ds, 2'b11);
    chk("t2_we", port1_we, 1);
    chk("t2_busy", busy, 1);

    // full word to port2
    wr_byte(P2B + 25'd2, 8'hAB);
    wr_byte(P2B + 25'd3, 8'hCD);
    n = 0;
    while (port2_req !== 1'b1 && n < 2) begin @(negedge clk); n++; end
    chk("t3_req", port2_req, 1);
    chk("t3_a", port2_a, 1);
    chk("t3_d", port2_d, 16'hCDAB);
    chk("t3_ds", port2_ds, 2'b11);
    chk("t3_p1", {port1_req, port1_a}, {1'b1, 23'd0});

    // back-pressure with port1 held
    wait_idle("t4_idle0");
    q1.delete();
    hold1 = 1'b1;
    for (int i = 0; i < 12; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) wr_byte(25'(i), b[i]);
    chk("t4_wait_lo", ioctl_wait, 0);
    for (int i = 6; i < 8; i++) wr_byte(25'(i), b[i]);
    chk("t4_wait_hi", ioctl_wait, 1);
    hold1 = 1'b0;
    for (int i = 8; i < 12; i++) wr_byte(25'(i), b[i]);
    wait_idle("t4_idle1");
    chk("t4_cnt", q1.size(), 6);
    for (int i = 0; i < 6 && i < q1.size(); i++)
      chk($sformatf("t4_w%0d", i), q1[i], {23'(i), b[2*i+1], b[2*i], 2'b11});

    // flush of a trailing even byte and done
    q1.delete();
    d0 = done_cnt;
    for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 3; i++) wr_byte(25'(i), b[i]);
    ioctl_download = 1'b0;
    wait_done(d0, 200, "t5_done");
    chk("t5_done_after_ack", done_idle, 1);
    chk("t5_cnt", q1.size(), 2);
    if (q1.size() == 2) chk("t5_last", {q1[1][40:18], q1[1][9:2], q1[1][1:0]}, {23'd1, b[2], 2'b01});
    repeat (5) @(negedge clk);
    chk("t5_once", done_cnt, d0 + 1);
    chk("t5_busy", busy, 0);

    // new byte during drain returns to load and suppresses that done
    d0 = done_cnt;
    hold2 = 1'b1;
    ioctl_download = 1'b1;
    wr_byte(P2B + 25'd8, 8'($urandom));
    wr_byte(P2B + 25'd9, 8'($urandom));
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5b_drain_busy", busy, 1);
    ioctl_download = 1'b1;
    wr_byte(P2B + 25'd10, 8'($urandom));
    wr_byte(P2B + 25'd11, 8'($urandom));
    ioctl_download = 1'b0;
    hold2 = 1'b0;
    wait_done(d0, 300, "t5b_done");
    repeat (10) @(negedge clk);
    chk("t5b_once", done_cnt, d0 + 1);

    // randomized bursts across both regions, including dropped bytes
    d0 = done_cnt;
    ioctl_download = 1'b1;
    for (int k = 0; k < 12; k++) begin
      base = ($urandom_range(0, 1) == 1) ? int'(P2B) + int'($urandom_range(0, 63))
                                         : int'($urandom_range(0, 63));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        wr_byte(25'(base + i), 8'($urandom));
        if ($urandom_range(0, 9) == 0) wr_byte(25'(base + i) | 25'h1000000, 8'($urandom));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    ioctl_download = 1'b0;
    wait_done(d0, 2000, "rnd_done");
    chk("img_size", got_img.num(), exp_img.num());
    foreach (exp_img[k])
      chk($sformatf("img_%0h", k), got_img.exists(k) ? {1'b0, got_img[k]} : 9'h100, {1'b0, exp_img[k]});

    // reset during drain with port2 outstanding
    hold2 = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 16; i < 22; i++) wr_byte(P2B + 25'(i), 8'($urandom));
    ioctl_download = 1'b0;
    repeat (4) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_outstanding", port2_req ^ port2_ack, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hold2 = 1'b0;
    @(negedge clk);
    chk("t6_req", {port1_req, port2_req}, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_wait", ioctl_wait, 0);
    repeat (20) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_fifo_empty", {port1_req, port2_req, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
